// File: rtl/pic_pkg.sv
// Shared types and bit positions for the clocked 8259A-style bus control block.
package pic_pkg;

    // Initialisation sequencer states
    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } pic_state_e;

    // Command-word bit positions
    localparam int ICW1_SEL  = 4;
    localparam int OCW3_SEL  = 3;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_IC4  = 0;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;

    // Read-back select encoding
    localparam logic RSEL_IRR = 1'b0;
    localparam logic RSEL_ISR = 1'b1;

    // One bit per command-word write strobe
    typedef struct packed {
        logic icw1;
        logic icw2;
        logic icw3;
        logic icw4;
        logic ocw1;
        logic ocw2;
        logic ocw3;
    } pic_strobe_t;

endpackage

// File: rtl/pic_wr_capture.sv
// CPU write capture: holds data/a0 while wr_n is low and emits a one-cycle
// commit (vld_p0) on the first cycle wr_n is sampled high with a write pending.
module pic_wr_capture
    import pic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] cap_data_p0,
    output logic              cap_a0_p0,
    output logic              vld_p0
);

    logic wr_pend_p0;

    // Pending flag: set by a selected low wr_n, cleared by deselect during wr_n low or by commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pend_p0 <= 1'b0;
        end else if (!wr_n) begin
            wr_pend_p0 <= !cs_n;
        end else begin
            wr_pend_p0 <= 1'b0;
        end
    end

    // Data path capture; only meaningful while wr_pend_p0 is set, so no reset needed
    always_ff @(posedge clk) begin
        if (!wr_n && !cs_n) begin
            cap_data_p0 <= data_in;
            cap_a0_p0   <= a0;
        end
    end

    assign vld_p0 = wr_pend_p0 & wr_n;

endmodule

// File: rtl/pic_bus_control_seq.sv
// Clocked 8259A bus control: ICW/OCW decode with an initialisation sequencer,
// registered one-cycle write strobes, latched command word and read-back mux.
module pic_bus_control_seq
    import pic_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter bit INIT_RIS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] irr,
    input  logic [DATA_W-1:0] isr,
    input  logic [DATA_W-1:0] imr,
    output logic [DATA_W-1:0] cmd_word,
    output logic              icw1_wr,
    output logic              icw2_wr,
    output logic              icw3_wr,
    output logic              icw4_wr,
    output logic              ocw1_wr,
    output logic              ocw2_wr,
    output logic              ocw3_wr,
    output logic              sngl,
    output logic              ic4,
    output logic              ltim,
    output logic              init_done
);

    logic [DATA_W-1:0] cap_data_p0;
    logic              cap_a0_p0;
    logic              vld_p0;

    pic_state_e  state, state_nxt;
    logic        sngl_nxt, ic4_nxt, ltim_nxt;
    logic        rsel, rsel_nxt;
    pic_strobe_t strobe_nxt, strobe_p1;
    logic [1:0]  sel_bits;
    logic        icw1_hit;

    pic_wr_capture #(
        .DATA_W (DATA_W)
    ) u_wr_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .a0          (a0),
        .data_in     (data_in),
        .cap_data_p0 (cap_data_p0),
        .cap_a0_p0   (cap_a0_p0),
        .vld_p0      (vld_p0)
    );

    assign sel_bits = {cap_data_p0[ICW1_SEL], cap_data_p0[OCW3_SEL]};

    // D4=1 at a0=0 restarts initialisation from any state, except that READY
    // treats D4:D3=11 as a reserved command and drops it.
    assign icw1_hit = vld_p0 && !cap_a0_p0 && cap_data_p0[ICW1_SEL]
                      && !(state == READY && cap_data_p0[OCW3_SEL]);

    // State register plus registered strobes, configuration and command word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UNINIT;
            sngl      <= 1'b0;
            ic4       <= 1'b0;
            ltim      <= 1'b0;
            rsel      <= INIT_RIS;
            strobe_p1 <= '0;
            cmd_word  <= '0;
        end else begin
            state     <= state_nxt;
            sngl      <= sngl_nxt;
            ic4       <= ic4_nxt;
            ltim      <= ltim_nxt;
            rsel      <= rsel_nxt;
            strobe_p1 <= strobe_nxt;
            if (|strobe_nxt) begin
                cmd_word <= cap_data_p0;
            end
        end
    end

    // Next-state, ICW1 configuration and read-select update on each committed write
    always_comb begin
        state_nxt = state;
        sngl_nxt  = sngl;
        ic4_nxt   = ic4;
        ltim_nxt  = ltim;
        rsel_nxt  = rsel;
        if (icw1_hit) begin
            state_nxt = WAIT_ICW2;
            sngl_nxt  = cap_data_p0[ICW1_SNGL];
            ic4_nxt   = cap_data_p0[ICW1_IC4];
            ltim_nxt  = cap_data_p0[ICW1_LTIM];
            rsel_nxt  = INIT_RIS;
        end else if (vld_p0) begin
            case (state)
                WAIT_ICW2: begin
                    if (cap_a0_p0) begin
                        if (!sngl) begin
                            state_nxt = WAIT_ICW3;
                        end else if (ic4) begin
                            state_nxt = WAIT_ICW4;
                        end else begin
                            state_nxt = READY;
                        end
                    end
                end
                WAIT_ICW3: begin
                    if (cap_a0_p0) begin
                        state_nxt = ic4 ? WAIT_ICW4 : READY;
                    end
                end
                WAIT_ICW4: begin
                    if (cap_a0_p0) begin
                        state_nxt = READY;
                    end
                end
                READY: begin
                    if (!cap_a0_p0 && sel_bits == 2'b01 && cap_data_p0[OCW3_RR]) begin
                        rsel_nxt = cap_data_p0[OCW3_RIS];
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Strobe decode: at most one strobe per committed write
    always_comb begin
        strobe_nxt = '0;
        if (icw1_hit) begin
            strobe_nxt.icw1 = 1'b1;
        end else if (vld_p0) begin
            case (state)
                WAIT_ICW2: strobe_nxt.icw2 = cap_a0_p0;
                WAIT_ICW3: strobe_nxt.icw3 = cap_a0_p0;
                WAIT_ICW4: strobe_nxt.icw4 = cap_a0_p0;
                READY: begin
                    if (cap_a0_p0) begin
                        strobe_nxt.ocw1 = 1'b1;
                    end else if (sel_bits == 2'b00) begin
                        strobe_nxt.ocw2 = 1'b1;
                    end else if (sel_bits == 2'b01) begin
                        strobe_nxt.ocw3 = 1'b1;
                    end
                end
                default: strobe_nxt = '0;
            endcase
        end
    end

    assign icw1_wr   = strobe_p1.icw1;
    assign icw2_wr   = strobe_p1.icw2;
    assign icw3_wr   = strobe_p1.icw3;
    assign icw4_wr   = strobe_p1.icw4;
    assign ocw1_wr   = strobe_p1.ocw1;
    assign ocw2_wr   = strobe_p1.ocw2;
    assign ocw3_wr   = strobe_p1.ocw3;
    assign init_done = (state == READY);

    // Read-back mux; a concurrent write keeps the bus undriven
    always_comb begin
        data_oe  = ~rd_n & ~cs_n & wr_n;
        data_out = '0;
        if (data_oe) begin
            if (a0) begin
                data_out = imr;
            end else if (rsel == RSEL_ISR) begin
                data_out = isr;
            end else begin
                data_out = irr;
            end
        end
    end

endmodule

// File: tb/tb_pic_bus_control_seq.sv
// Bench for pic_bus_control_seq: expected strobe events are queued as writes
// are driven and matched against strobes the DUT produces.
module tb_pic_bus_control_seq;

    localparam int DATA_W = 8;
    localparam int S_ICW1 = 6;
    localparam int S_ICW2 = 5;
    localparam int S_ICW3 = 4;
    localparam int S_ICW4 = 3;
    localparam int S_OCW1 = 2;
    localparam int S_OCW2 = 1;
    localparam int S_OCW3 = 0;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              cs_n    = 1'b1;
    logic              rd_n    = 1'b1;
    logic              wr_n    = 1'b1;
    logic              a0      = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] irr     = 8'h3C;
    logic [DATA_W-1:0] isr     = 8'h05;
    logic [DATA_W-1:0] imr     = 8'hA5;

    logic [DATA_W-1:0] data_out, cmd_word;
    logic data_oe, icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr;
    logic sngl, ic4, ltim, init_done;

    pic_bus_control_seq #(
        .DATA_W   (DATA_W),
        .INIT_RIS (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .a0        (a0),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .irr       (irr),
        .isr       (isr),
        .imr       (imr),
        .cmd_word  (cmd_word),
        .icw1_wr   (icw1_wr),
        .icw2_wr   (icw2_wr),
        .icw3_wr   (icw3_wr),
        .icw4_wr   (icw4_wr),
        .ocw1_wr   (ocw1_wr),
        .ocw2_wr   (ocw2_wr),
        .ocw3_wr   (ocw3_wr),
        .sngl      (sngl),
        .ic4       (ic4),
        .ltim      (ltim),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] vec;
        logic [7:0] cmd;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;

    wire [6:0] stb = {icw1_wr, icw2_wr, icw3_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr};

    // Scoreboard: every strobe cycle must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && stb != 7'd0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: strobes=%b cmd_word=%h at cycle %0d, required no strobe",
                         stb, cmd_word, cyc);
            end else begin
                got_e = sb.pop_front();
                if (stb !== got_e.vec || cmd_word !== got_e.cmd || cyc != got_e.cyc) begin
                    n_err++;
                    $display("FAIL strobe_event: strobes=%b cmd_word=%h cycle=%0d, required strobes=%b cmd_word=%h cycle=%0d",
                             stb, cmd_word, cyc, got_e.vec, got_e.cmd, got_e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // One full write cycle followed by exactly one wr_n-high cycle; sidx<0 means ignored
    task automatic wr(input logic a, input logic [7:0] d, input int sidx);
        exp_t x;
        cs_n    = 1'b0;
        a0      = a;
        data_in = d;
        wr_n    = 1'b0;
        tick();
        wr_n = 1'b1;
        cs_n = 1'b1;
        if (sidx >= 0) begin
            x.vec = 7'(1 << sidx);
            x.cmd = d;
            x.cyc = cyc + 1;
            sb.push_back(x);
        end
        tick();
    endtask

    task automatic rd_on(input logic a);
        cs_n = 1'b0;
        rd_n = 1'b0;
        a0   = a;
        settle();
    endtask

    task automatic rd_off();
        rd_n = 1'b1;
        cs_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick(); tick();
        settle();
        n_vec++;
        if ({stb, cmd_word, sngl, ic4, ltim, init_done, data_oe, data_out} !== 28'h0) begin
            n_err++;
            $display("FAIL reset_outputs: strobes=%b cmd=%h cfg=%b done=%b oe=%b dout=%h, required all 0",
                     stb, cmd_word, {sngl, ic4, ltim}, init_done, data_oe, data_out);
        end
        rst_n = 1'b1;
        rd_on(1'b0);
        n_vec++;
        if (data_out !== 8'h3C || data_oe !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rsel_irr: dout=%h oe=%b, required 3c 1", data_out, data_oe);
        end
        rd_off();
    endtask

    task automatic test_init_single();
        wr(1'b0, 8'h13, S_ICW1);
        settle();
        n_vec++;
        if ({sngl, ic4, ltim, init_done} !== 4'b1100) begin
            n_err++;
            $display("FAIL icw1_cfg_13: sngl/ic4/ltim/done=%b, required 1100", {sngl, ic4, ltim, init_done});
        end
        wr(1'b1, 8'h20, S_ICW2);
        settle();
        n_vec++;
        if (init_done !== 1'b0) begin
            n_err++;
            $display("FAIL single_done_early: init_done=%b, required 0", init_done);
        end
        wr(1'b1, 8'h01, S_ICW4);
        settle();
        n_vec++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL single_done: init_done=%b, required 1", init_done);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL single_drain: %0d strobes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_init_cascade();
        wr(1'b0, 8'h10, S_ICW1);
        settle();
        n_vec++;
        if ({sngl, ic4, ltim, init_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL icw1_cfg_10: sngl/ic4/ltim/done=%b, required 0000", {sngl, ic4, ltim, init_done});
        end
        wr(1'b1, 8'h08, S_ICW2);
        wr(1'b0, 8'h08, -1);
        wr(1'b1, 8'h04, S_ICW3);
        settle();
        n_vec++;
        if (init_done !== 1'b1 || cmd_word !== 8'h04) begin
            n_err++;
            $display("FAIL cascade_done: init_done=%b cmd=%h, required 1 04", init_done, cmd_word);
        end
        wr(1'b1, 8'hFF, S_OCW1);
        settle();
        n_vec++;
        if (cmd_word !== 8'hFF) begin
            n_err++;
            $display("FAIL ocw1_cmd: cmd=%h, required ff", cmd_word);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL cascade_drain: %0d strobes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_read_select();
        wr(1'b0, 8'h0B, S_OCW3);
        rd_on(1'b0);
        n_vec++;
        if (data_out !== 8'h05 || data_oe !== 1'b1) begin
            n_err++;
            $display("FAIL rd_isr_0b: dout=%h oe=%b, required 05 1", data_out, data_oe);
        end
        rd_off();
        wr(1'b0, 8'h08, S_OCW3);
        rd_on(1'b0);
        n_vec++;
        if (data_out !== 8'h05) begin
            n_err++;
            $display("FAIL rd_keep_isr_08: dout=%h, required 05", data_out);
        end
        rd_off();
        wr(1'b0, 8'h0A, S_OCW3);
        rd_on(1'b0);
        n_vec++;
        if (data_out !== 8'h3C) begin
            n_err++;
            $display("FAIL rd_irr_0a: dout=%h, required 3c", data_out);
        end
        rd_off();
        wr(1'b0, 8'h20, S_OCW2);
        rd_on(1'b1);
        n_vec++;
        if (data_out !== 8'hA5 || data_oe !== 1'b1) begin
            n_err++;
            $display("FAIL rd_imr: dout=%h oe=%b, required a5 1", data_out, data_oe);
        end
        cs_n = 1'b1;
        settle();
        n_vec++;
        if (data_out !== 8'h00 || data_oe !== 1'b0) begin
            n_err++;
            $display("FAIL rd_deselected: dout=%h oe=%b, required 00 0", data_out, data_oe);
        end
        rd_off();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL rsel_drain: %0d strobes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        wr(1'b1, 8'hA1, S_OCW1);
        wr(1'b0, 8'h00, S_OCW2);
        wr(1'b0, 8'h09, S_OCW3);
        wr(1'b1, 8'h5A, S_OCW1);
        settle();
        n_vec++;
        if (sb.size() != 0 || cmd_word !== 8'h5A) begin
            n_err++;
            $display("FAIL b2b_drain: outstanding=%0d cmd=%h, required 0 5a", sb.size(), cmd_word);
            sb.delete();
        end
    endtask

    task automatic test_abort_and_rdwr();
        cs_n    = 1'b0;
        a0      = 1'b1;
        data_in = 8'h99;
        wr_n    = 1'b0;
        tick();
        cs_n = 1'b1;
        tick();
        wr_n = 1'b1;
        tick(); tick();
        settle();
        n_vec++;
        if (cmd_word !== 8'h5A) begin
            n_err++;
            $display("FAIL abort_cmd: cmd=%h, required 5a", cmd_word);
        end
        cs_n    = 1'b0;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        a0      = 1'b1;
        data_in = 8'h3C;
        settle();
        n_vec++;
        if (data_oe !== 1'b0 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL rdwr_oe: oe=%b dout=%h, required 0 00", data_oe, data_out);
        end
        tick();
        wr_n = 1'b1;
        rd_n = 1'b1;
        cs_n = 1'b1;
        got_e.vec = 7'(1 << S_OCW1);
        got_e.cmd = 8'h3C;
        got_e.cyc = cyc + 1;
        sb.push_back(got_e);
        tick();
        settle();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL rdwr_drain: %0d strobes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reinit_reset();
        wr(1'b0, 8'h10, S_ICW1);
        wr(1'b1, 8'h08, S_ICW2);
        wr(1'b0, 8'h1A, S_ICW1);
        settle();
        n_vec++;
        if ({sngl, ic4, ltim, init_done} !== 4'b1010) begin
            n_err++;
            $display("FAIL reinit_cfg_1a: sngl/ic4/ltim/done=%b, required 1010", {sngl, ic4, ltim, init_done});
        end
        cs_n    = 1'b0;
        a0      = 1'b0;
        data_in = 8'h13;
        wr_n    = 1'b0;
        tick();
        rst_n = 1'b0;
        settle();
        n_vec++;
        if ({stb, cmd_word, sngl, ic4, ltim, init_done, data_oe, data_out} !== 28'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: strobes=%b cmd=%h cfg=%b done=%b oe=%b dout=%h, required all 0",
                     stb, cmd_word, {sngl, ic4, ltim}, init_done, data_oe, data_out);
        end
        wr_n = 1'b1;
        cs_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        settle();
        n_vec++;
        if (cmd_word !== 8'h00 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL pending_discard: cmd=%h done=%b, required 00 0", cmd_word, init_done);
        end
        wr(1'b1, 8'h21, -1);
        settle();
        n_vec++;
        if (cmd_word !== 8'h00) begin
            n_err++;
            $display("FAIL postreset_a1: cmd=%h, required 00", cmd_word);
        end
    endtask

    task automatic test_uninit();
        wr(1'b0, 8'h00, -1);
        wr(1'b1, 8'h55, -1);
        settle();
        n_vec++;
        if (cmd_word !== 8'h00 || init_done !== 1'b0) begin
            n_err++;
            $display("FAIL uninit_ignore: cmd=%h done=%b, required 00 0", cmd_word, init_done);
        end
        wr(1'b0, 8'h12, S_ICW1);
        wr(1'b1, 8'h40, S_ICW2);
        settle();
        n_vec++;
        if (init_done !== 1'b1 || {sngl, ic4} !== 2'b10) begin
            n_err++;
            $display("FAIL single_noicw4: done=%b sngl/ic4=%b, required 1 10", init_done, {sngl, ic4});
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL uninit_drain: %0d strobes outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_init_single();
        test_init_cascade();
        test_read_select();
        test_back_to_back();
        test_abort_and_rdwr();
        test_reinit_reset();
        test_uninit();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
